// File: rtl/rst_sequencer.sv
// Reset sequencer: holds every stage, releases them one by one with
// per-stage dwell (optionally gated by stage_done), then raises run_en.
module rst_sequencer #(
    parameter int N_STAGES   = 4,
    parameter int CNT_W      = 32,
    parameter int PRE_TIME   = 20,
    parameter int TIMEOUT    = 1000,
    parameter int AUTO_START = 1,
    parameter int IDX_W      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      wait_done,
    input  logic [N_STAGES*CNT_W-1:0] dur_i,
    input  logic [N_STAGES-1:0]       stage_done,
    output logic [N_STAGES-1:0]       stage_rst,
    output logic                      run_en,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [IDX_W-1:0]          cur_stage
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_REL, S_RUN, S_ERR} state_t;

    localparam state_t RST_STATE = (AUTO_START != 0) ? S_PRE : S_IDLE;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_STAGES - 1);

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, dur_q, dur_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic adv;

    logic [N_STAGES-1:0] stage_rst_nx;
    logic run_en_nx, busy_nx, done_nx, err_nx;
    logic [IDX_W-1:0] cur_nx;

    function automatic logic [CNT_W-1:0] dur_of(input logic [IDX_W-1:0] k);
        return dur_i[CNT_W*int'(k) +: CNT_W];
    endfunction

    // Stages 0..k released, everything above still held.
    function automatic logic [N_STAGES-1:0] rel_mask(input logic [IDX_W-1:0] k);
        logic [N_STAGES-1:0] m;
        for (int j = 0; j < N_STAGES; j++) m[j] = (j > int'(k));
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RST_STATE;
            cnt       <= '0;
            idx       <= '0;
            dur_q     <= '0;
            stage_rst <= '1;
            run_en    <= 1'b0;
            busy      <= (AUTO_START != 0);
            done      <= 1'b0;
            err       <= 1'b0;
            cur_stage <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            dur_q     <= dur_nx;
            stage_rst <= stage_rst_nx;
            run_en    <= run_en_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
            cur_stage <= cur_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        dur_nx   = dur_q;
        adv      = (cnt >= dur_q) && (!wait_done || stage_done[idx]);
        if (abort) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else if (start && (state inside {S_IDLE, S_RUN, S_ERR})) begin
            state_nx = S_PRE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            unique case (state)
                S_PRE: begin
                    if (cnt == CNT_W'(PRE_TIME)) begin
                        state_nx = S_REL;
                        cnt_nx   = '0;
                        idx_nx   = '0;
                        dur_nx   = dur_of('0);
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_REL: begin
                    // A done flag arriving on the timeout cycle still advances.
                    if (adv) begin
                        if (idx == LAST) begin
                            state_nx = S_RUN;
                        end else begin
                            idx_nx = idx + 1'b1;
                            cnt_nx = '0;
                            dur_nx = dur_of(idx_nx);
                        end
                    end else if (wait_done && cnt == CNT_W'(TIMEOUT)) begin
                        state_nx = S_ERR;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stage_rst_nx = '1;
        run_en_nx    = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        cur_nx       = '0;
        unique case (state_nx)
            S_PRE: busy_nx = 1'b1;
            S_REL: begin
                busy_nx      = 1'b1;
                stage_rst_nx = rel_mask(idx_nx);
                cur_nx       = idx_nx;
            end
            S_RUN: begin
                stage_rst_nx = '0;
                run_en_nx    = 1'b1;
                done_nx      = (state != S_RUN);
            end
            S_ERR: begin
                err_nx = 1'b1;
                cur_nx = idx_nx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: timing tables, corner sequences and a
// randomized run against a timestamp-based reference model.
module tb_rst_sequencer;

    localparam int PRE_T = 20;
    localparam int TMO   = 1000;
    localparam int P_IDLE = 0, P_PRE = 1, P_REL = 2, P_RUN = 3, P_ERR = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic wait_done = 1'b0;
    logic [127:0] dur_i = '0;
    logic [3:0] stage_done = '0;
    logic [3:0] stage_rst;
    logic run_en, busy, done, err;
    logic [1:0] cur_stage;

    int checks = 0;
    int errors = 0;
    int e = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    rst_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wait_done(wait_done), .dur_i(dur_i), .stage_done(stage_done),
        .stage_rst(stage_rst), .run_en(run_en), .busy(busy),
        .done(done), .err(err), .cur_stage(cur_stage)
    );

    always #5 clk = ~clk;

    // Model: phase, stage, edge number at which the phase was entered.
    typedef struct {
        int ph;
        int st;
        int t0;
        logic [31:0] d;
    } m_t;

    m_t m;

    function automatic m_t enter(input m_t x, input int k, input int c);
        m_t r;
        r = x;
        r.ph = P_REL;
        r.st = k;
        r.t0 = c;
        r.d = dur_i[k*32 +: 32];
        return r;
    endfunction

    function automatic m_t mstep(input m_t x, input int c);
        m_t r;
        int el;
        r = x;
        el = c - x.t0 - 1;
        if (abort) begin
            r.ph = P_IDLE;
        end else if (start && x.ph != P_PRE && x.ph != P_REL) begin
            r.ph = P_PRE;
            r.t0 = c;
        end else if (x.ph == P_PRE && el == PRE_T) begin
            r = enter(x, 0, c);
        end else if (x.ph == P_REL) begin
            if (el >= int'(x.d) && (!wait_done || stage_done[x.st])) begin
                if (x.st == 3) begin
                    r.ph = P_RUN;
                    r.t0 = c;
                end else begin
                    r = enter(x, x.st + 1, c);
                end
            end else if (wait_done && el == TMO) begin
                r.ph = P_ERR;
            end
        end
        return r;
    endfunction

    function automatic logic [9:0] exp_out(input m_t x, input int c);
        logic [3:0] sr;
        logic rn, bz, dn, er;
        logic [1:0] cs;
        sr = 4'hF; rn = 0; bz = 0; dn = 0; er = 0; cs = 0;
        case (x.ph)
            P_PRE: bz = 1;
            P_REL: begin bz = 1; sr = 4'hF << (x.st + 1); cs = 2'(x.st); end
            P_RUN: begin sr = 4'h0; rn = 1; dn = (c == x.t0); end
            P_ERR: begin er = 1; cs = 2'(x.st); end
            default: ;
        endcase
        return {sr, rn, bz, dn, er, cs};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= '{ph: P_PRE, st: 0, t0: 0, d: 32'd0};
            cyc <= 0;
        end else begin
            m <= mstep(m, cyc + 1);
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en)
            chk("model", {stage_rst, run_en, busy, done, err, cur_stage}, exp_out(m, cyc));
    end

    task automatic goto(input int n);
        while (e < n) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0;
    endtask

    task automatic set_dur(input int d3, input int d2, input int d1, input int d0);
        dur_i = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
    endtask

    typedef struct {
        int n;
        logic [3:0] sr;
        logic rn;
        logic bz;
        logic dn;
    } vec_t;

    vec_t tbl[12];

    task automatic run_table(input string tag);
        for (int i = 0; i < 12; i++) begin
            goto(tbl[i].n);
            chk($sformatf("%s@%0d", tag, tbl[i].n), {stage_rst, run_en, busy, done},
                {tbl[i].sr, tbl[i].rn, tbl[i].bz, tbl[i].dn});
        end
    endtask

    initial begin
        tbl[0]  = '{0,   4'hF, 0, 1, 0};
        tbl[1]  = '{20,  4'hF, 0, 1, 0};
        tbl[2]  = '{21,  4'hE, 0, 1, 0};
        tbl[3]  = '{41,  4'hE, 0, 1, 0};
        tbl[4]  = '{42,  4'hC, 0, 1, 0};
        tbl[5]  = '{442, 4'hC, 0, 1, 0};
        tbl[6]  = '{443, 4'h8, 0, 1, 0};
        tbl[7]  = '{643, 4'h8, 0, 1, 0};
        tbl[8]  = '{644, 4'h0, 0, 1, 0};
        tbl[9]  = '{844, 4'h0, 0, 1, 0};
        tbl[10] = '{845, 4'h0, 1, 0, 1};
        tbl[11] = '{846, 4'h0, 1, 0, 0};

        set_dur(200, 200, 400, 20);
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset", {stage_rst, run_en, busy, done, err, cur_stage}, {4'hF, 6'b010000});

        // Default timing from reset release, then a re-sequence from RUN.
        rst = 1'b1;
        e = 0;
        run_table("por");
        goto(850);
        pulse_start();
        chk("reseq_pre", {stage_rst, run_en, busy}, {4'hF, 2'b01});
        run_table("reseq");

        // Done handshake: stage 1 stalls until its flag appears.
        wait_done = 1'b1;
        set_dur(5, 5, 5, 5);
        stage_done = 4'b1101;
        pulse_start();
        goto(57);
        chk("wd_s1_hold", stage_rst, 4'hC);
        stage_done = 4'b1111;
        goto(58);
        chk("wd_s1_rel", stage_rst, 4'h8);
        goto(63);
        chk("wd_s2_hold", stage_rst, 4'h8);
        goto(64);
        chk("wd_s3_rel", stage_rst, 4'h0);
        goto(70);
        chk("wd_run", {run_en, done}, 2'b11);

        // Timeout on stage 2, then recovery through start.
        stage_done = 4'b1011;
        pulse_start();
        goto(1033);
        chk("tmo_before", {stage_rst, err}, {4'h8, 1'b0});
        goto(1034);
        chk("tmo_err", {stage_rst, run_en, busy, err, cur_stage}, {4'hF, 3'b001, 2'd2});
        goto(1040);
        chk("tmo_sticky", {err, cur_stage}, {1'b1, 2'd2});
        stage_done = 4'b1111;
        pulse_start();
        chk("tmo_clear", {err, busy}, 2'b01);
        goto(45);
        chk("tmo_rerun", {run_en, done}, 2'b11);

        // Abort in stage 1, idle stays idle, start+abort together idles.
        wait_done = 1'b0;
        pulse_start();
        goto(30);
        chk("ab_s1", {stage_rst, cur_stage}, {4'hC, 2'd1});
        abort = 1'b1;
        goto(31);
        abort = 1'b0;
        chk("ab_idle", {stage_rst, run_en, busy, cur_stage}, {4'hF, 2'b00, 2'd0});
        goto(90);
        chk("ab_stay", {stage_rst, run_en, busy}, {4'hF, 2'b00});
        abort = 1'b1;
        pulse_start();
        abort = 1'b0;
        chk("ab_start_both", {stage_rst, busy}, {4'hF, 1'b0});
        pulse_start();
        chk("ab_restart", busy, 1'b1);

        // Mid-stage dur_i change only affects later stages.
        set_dur(5, 5, 5, 5);
        goto(60);
        chk("lat_run", run_en, 1'b1);
        pulse_start();
        goto(28);
        set_dur(10, 10, 10, 10);
        goto(32);
        chk("lat_s1_hold", stage_rst, 4'hC);
        goto(33);
        chk("lat_s2_rel", stage_rst, 4'h8);
        goto(43);
        chk("lat_s2_hold", stage_rst, 4'h8);
        goto(44);
        chk("lat_s3_rel", stage_rst, 4'h0);
        goto(55);
        chk("lat_run2", {run_en, done}, 2'b11);

        // Zero dwell: one cycle per stage.
        set_dur(0, 0, 0, 0);
        pulse_start();
        goto(21);
        chk("z_s0", stage_rst, 4'hE);
        goto(22);
        chk("z_s1", stage_rst, 4'hC);
        goto(23);
        chk("z_s2", stage_rst, 4'h8);
        goto(24);
        chk("z_s3", stage_rst, 4'h0);
        goto(25);
        chk("z_run", {run_en, done, busy}, 3'b110);

        // Asynchronous reset in the middle of a release.
        pulse_start();
        goto(22);
        #2 rst = 1'b0;
        #1 chk("arst", {stage_rst, run_en, busy, done, err, cur_stage}, {4'hF, 6'b010000});
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 39) == 0);
            abort = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 63) == 0) wait_done = ~wait_done;
            stage_done = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 15) == 0)
                for (int k = 0; k < 4; k++) dur_i[k*32 +: 32] = $urandom_range(0, 7);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised power-on / restart reset sequencer. Releases N_STAGES downstream stage resets one at a time, then asserts a final run enable.
- Sits at top level and drives the per-stage reset inputs of the memory, PE, window and display blocks.
- Per-stage dwell times come from a port. An optional mode waits for each stage's done flag, with a timeout.
- Adds start/abort control, re-sequencing, and error reporting.

Parameters:
- N_STAGES, 4, number of sequenced stage resets (≥1).
- CNT_W, 32, dwell/timeout counter width.
- PRE_TIME, 20, dwell of the initial all-held phase.
- TIMEOUT, 1000, max cycles per stage in wait mode; must exceed every dur.
- AUTO_START, 1, 1 means the sequence starts from reset without a start pulse.
- IDX_W, $clog2(N_STAGES) (min 1), stage index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins or restarts the sequence
- abort  in  1  one-cycle pulse; forces all stages back into reset and returns to idle
- wait_done  in  1  1 means a stage advance also requires stage_done[idx]
- dur_i  in  N_STAGES*CNT_W  dwell per stage; stage k uses bits [k*CNT_W +: CNT_W]
- stage_done  in  N_STAGES  per-stage ready flags
- stage_rst  out  N_STAGES  1 means stage held in reset
- run_en  out  1  final enable (display/run)
- busy  out  1  sequence in progress (PRE or REL)
- done  out  1  one-cycle pulse on entry to RUN
- err  out  1  timeout error, sticky until start/abort
- cur_stage  out  IDX_W  index of the stage being released; held in ERR

Behaviour:
- States: IDLE, PRE, REL, RUN, ERR. All outputs are registered and change on the same edge the state is entered.
- Reset values:
  - state = PRE if AUTO_START else IDLE; counter = 0; idx = 0.
  - stage_rst = all 1; run_en = 0; done = 0; err = 0; cur_stage = 0.
  - busy = AUTO_START.
- IDLE:
  - stage_rst all 1, run_en 0, busy 0.
  - start → PRE with counter = 0.
- PRE:
  - All stages held, busy 1.
  - When counter == PRE_TIME → REL with idx = 0 and counter = 0; otherwise counter += 1.
  - Dwell is PRE_TIME+1 cycles.
- REL (stage idx):
  - stage_rst[j] = 0 for j ≤ idx, 1 for j > idx.
  - dur[idx] is latched on entry; changes to dur_i mid-stage are ignored.
  - Advance condition: counter ≥ dur and (!wait_done or stage_done[idx]).
  - On advance: if idx == N_STAGES-1 → RUN, else idx += 1 and counter = 0.
  - With wait_done = 0, dwell is dur+1 cycles; dur = 0 gives a 1-cycle dwell.
  - With wait_done = 1, if counter == TIMEOUT and the advance condition is false → ERR.
  - stage_done and timeout in the same cycle: advance wins.
  - The counter does not wrap while waiting, because TIMEOUT < 2^CNT_W.
- RUN:
  - stage_rst all 0, run_en 1, busy 0; done pulses for the entry cycle only.
  - start → PRE (re-sequence: all stages re-held, run_en 0).
- ERR:
  - stage_rst all 1, run_en 0, err 1, busy 0; cur_stage holds the failing idx.
  - start → PRE with err cleared; abort → IDLE with err cleared.
- Priority: abort > start > normal progression.
  - abort in any state → IDLE, all stages held, run_en 0.
  - start while in PRE or REL is ignored.
- Asynchronous rst mid-sequence returns immediately to reset values; no partial release persists.
- stage_rst bits deassert monotonically (stage 0 first) and re-assert together.
- cur_stage = idx in REL/ERR, 0 elsewhere.

Test Plan:
1. Defaults, dur = {200,200,400,20} (stage3..0), wait_done = 0, release rst: stage_rst[0] falls at edge 21, [1] at 42, [2] at 443, [3] at 644; run_en and done rise at edge 845; done is low at 846; busy falls at 845.
2. wait_done = 1, dur all 5, stage_done[1] raised 30 cycles into stage 1 → stage 1 dwells exactly 31 cycles; stages 0, 2, 3 dwell 6 cycles with stage_done high.
3. wait_done = 1, stage_done[2] never set → at counter 1000 in stage 2: ERR, err = 1, cur_stage = 2, stage_rst = 4'b1111. Then start → PRE, err = 0, sequence reruns.
4. abort in REL at stage 1 → next edge: IDLE, stage_rst = 1111, busy = 0. With AUTO_START irrelevant, no progress until start.
5. In RUN, pulse start → PRE, run_en = 0, stage_rst = 1111, and the full timing of scenario 1 repeats relative to that edge. start and abort in the same cycle → IDLE.
6. dur_i changed during stage 1 → stage 1 uses the latched value; stage 2 uses the new value. Also: dur = 0 on all stages gives 1 cycle per stage. Also: rst asserted mid-REL → outputs return to reset values asynchronously.
